// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: XNOR tap table, checker FSM encoding and legal width range.
// Used by both the LFSR generator and lfsr_checker.
package lfsr_pkg;

   localparam int LFSR_MIN_BITS = 3;
   localparam int LFSR_MAX_BITS = 32;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   // Maximal-length XNOR taps; bit k-1 set for tap k.
   function automatic logic [31:0] lfsr_taps(input int n);
      case (n)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-word predictor for the XNOR LFSR (shift left, feedback into bit 0).
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int NUM_BITS = 4
) (
   input  logic [NUM_BITS-1:0] cur,
   output logic [NUM_BITS-1:0] nxt
);

   localparam logic [31:0]         TAPS = lfsr_taps(NUM_BITS);
   localparam logic [NUM_BITS-1:0] MASK = TAPS[NUM_BITS-1:0];

   assign nxt = {cur[NUM_BITS-2:0], ~^(cur & MASK)};

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: locks to the received word stream and counts errors.
// Optional period measurement enabled by defining LFSR_CHECK_PERIOD_EN.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int NUM_BITS     = 4,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 3,
   parameter int ERR_CNT_BITS = 16
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic                    i_Clear,
   input  logic                    i_LFSR_DV,
   input  logic [NUM_BITS-1:0]     i_LFSR_Data,
   output logic                    o_Locked,
   output logic                    o_Error,
   output logic [ERR_CNT_BITS-1:0] o_Error_Count,
   output logic                    o_Lockup,
   output logic [NUM_BITS:0]       o_Period,
   output logic                    o_Period_DV
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int UW = $clog2(UNLOCK_COUNT + 1);
   localparam int PW = NUM_BITS + 1;

   logic [1:0]          state;
   logic [NUM_BITS-1:0] prev, pred;
   logic [MW-1:0]       match_cnt;
   logic [UW-1:0]       miss_cnt;
   logic                match, enter_lock, miss, drop_lock;

   lfsr_next #(.NUM_BITS(NUM_BITS)) u_next (.cur(prev), .nxt(pred));

   always_comb begin
      match      = (i_LFSR_Data == pred);
      enter_lock = i_LFSR_DV && (state == ST_ACQUIRE) && match &&
                   (int'(match_cnt) + 1 >= LOCK_COUNT);
      miss       = i_LFSR_DV && (state == ST_LOCKED) && !match;
      drop_lock  = miss && (int'(miss_cnt) + 1 >= UNLOCK_COUNT);
   end

   // prev always reloads from the received word, so the checker re-syncs on its own
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state         <= ST_IDLE;
         prev          <= '0;
         match_cnt     <= '0;
         miss_cnt      <= '0;
         o_Locked      <= 1'b0;
         o_Error       <= 1'b0;
         o_Lockup      <= 1'b0;
         o_Error_Count <= '0;
      end else begin
         o_Error  <= miss;
         o_Lockup <= i_LFSR_DV && (i_LFSR_Data == {NUM_BITS{1'b1}});
         if (i_Clear)
            o_Error_Count <= '0;
         else if (miss && (o_Error_Count != {ERR_CNT_BITS{1'b1}}))
            o_Error_Count <= o_Error_Count + ERR_CNT_BITS'(1);
         if (i_LFSR_DV) begin
            prev <= i_LFSR_Data;
            case (state)
               ST_IDLE: begin
                  state     <= ST_ACQUIRE;
                  match_cnt <= '0;
               end
               ST_ACQUIRE: begin
                  if (enter_lock) begin
                     state     <= ST_LOCKED;
                     o_Locked  <= 1'b1;
                     match_cnt <= '0;
                     miss_cnt  <= '0;
                  end else if (match)
                     match_cnt <= match_cnt + MW'(1);
                  else
                     match_cnt <= '0;
               end
               ST_LOCKED: begin
                  if (drop_lock) begin
                     state     <= ST_ACQUIRE;
                     o_Locked  <= 1'b0;
                     match_cnt <= '0;
                     miss_cnt  <= '0;
                  end else if (miss)
                     miss_cnt <= miss_cnt + UW'(1);
                  else
                     miss_cnt <= '0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef LFSR_CHECK_PERIOD_EN
   logic [NUM_BITS-1:0] anchor;
   logic [PW-1:0]       period_cnt, period_inc;

   assign period_inc = (period_cnt == {PW{1'b1}}) ? period_cnt : period_cnt + PW'(1);

   // Measurement restarts from the word that completed lock; leaving LOCKED abandons it
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         anchor      <= '0;
         period_cnt  <= '0;
         o_Period    <= '0;
         o_Period_DV <= 1'b0;
      end else begin
         o_Period_DV <= 1'b0;
         if (enter_lock) begin
            anchor     <= i_LFSR_Data;
            period_cnt <= '0;
         end else if (i_LFSR_DV && (state == ST_LOCKED) && !drop_lock) begin
            if (i_LFSR_Data == anchor) begin
               o_Period    <= period_inc;
               o_Period_DV <= 1'b1;
               period_cnt  <= '0;
            end else
               period_cnt <= period_inc;
         end
      end
   end
`else
   assign o_Period    = '0;
   assign o_Period_DV = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (NUM_BITS=4); a second instance with a 2-bit error counter
// shares the stimulus to exercise counter saturation.
module tb_lfsr_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       dv  = 1'b0;
   logic [3:0] data = 4'h0;

   logic        locked, error, lockup, period_dv;
   logic [15:0] err_count;
   logic [4:0]  period;
   logic        s_locked, s_error, s_lockup, s_period_dv;
   logic [1:0]  s_err_count;
   logic [4:0]  s_period;

   always #5 clk = ~clk;

   lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_BITS(16)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Clear(clr), .i_LFSR_DV(dv), .i_LFSR_Data(data),
      .o_Locked(locked), .o_Error(error), .o_Error_Count(err_count), .o_Lockup(lockup),
      .o_Period(period), .o_Period_DV(period_dv));

   lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_BITS(2)) dut_sat (
      .i_Clk(clk), .i_Rst(rst), .i_Clear(clr), .i_LFSR_DV(dv), .i_LFSR_Data(data),
      .o_Locked(s_locked), .o_Error(s_error), .o_Error_Count(s_err_count), .o_Lockup(s_lockup),
      .o_Period(s_period), .o_Period_DV(s_period_dv));

   // Hand-computed sequence from seed 0, taps 4,3 XNOR
   logic [3:0] seq [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

   int         n_tests = 0, n_fail = 0;
   int         err_pulses = 0, lockup_pulses = 0, pdv_pulses = 0, drops = 0;
   logic [4:0] last_period = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic v, input logic [3:0] d, input logic c);
      @(negedge clk);
      dv = v; data = d; clr = c;
      @(posedge clk);
      #1;
      err_pulses    += int'(error);
      lockup_pulses += int'(lockup);
      pdv_pulses    += int'(period_dv);
      if (!locked) drops++;
      if (period_dv) last_period = period;
   endtask

   task automatic push_seq(input int i);
      push(1'b1, seq[i % 15], 1'b0);
   endtask

   initial begin
      #12;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_count", 32'(err_count), 32'd0);
      check("rst_lockup", 32'(lockup), 32'd0);
      check("rst_period", 32'(period), 32'd0);
      check("rst_period_dv", 32'(period_dv), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Acquire: 1 capture + 4 matches
      for (int i = 0; i < 5; i++) begin
         push_seq(i);
         if (i == 3) check("t1_lock_pre", 32'(locked), 32'd0);
      end
      check("t1_lock", 32'(locked), 32'd1);
      for (int i = 5; i < 20; i++) push_seq(i);
      check("t1_no_err", 32'(err_pulses), 32'd0);
      check("t1_count", 32'(err_count), 32'd0);
`ifdef LFSR_CHECK_PERIOD_EN
      check("t5_period_dv", 32'(pdv_pulses), 32'd1);
      check("t5_period", 32'(last_period), 32'd15);
`else
      check("t5_period_dv_off", 32'(pdv_pulses), 32'd0);
      check("t5_period_off", 32'(period), 32'd0);
`endif
      push(1'b0, 4'h5, 1'b0);
      push(1'b0, 4'h5, 1'b0);
      check("idle_dv_lock", 32'(locked), 32'd1);
      check("idle_dv_err", 32'(err_pulses), 32'd0);

      // Single corrupted word -> two counted mismatches, lock held
      drops = 0;
      push(1'b1, seq[5] ^ 4'h1, 1'b0);
      for (int i = 21; i < 25; i++) push_seq(i);
      check("t2_pulses", 32'(err_pulses), 32'd2);
      check("t2_count", 32'(err_count), 32'd2);
      check("t2_drops", 32'(drops), 32'd0);

      push(1'b0, 4'h0, 1'b1);
      check("clr_count", 32'(err_count), 32'd0);
      push(1'b1, seq[10] ^ 4'h1, 1'b1);
      check("clr_err_pulse", 32'(error), 32'd1);
      check("clr_err_count", 32'(err_count), 32'd0);
      push_seq(26);
      check("clr_next_pulse", 32'(error), 32'd1);
      check("clr_next_count", 32'(err_count), 32'd1);
      for (int i = 27; i < 30; i++) push_seq(i);
      check("clr_lock", 32'(locked), 32'd1);

      // Three garbage words drop lock
      push(1'b1, 4'h5, 1'b0);
      push(1'b1, 4'h5, 1'b0);
      check("t3_lock_hold", 32'(locked), 32'd1);
      push(1'b1, 4'h5, 1'b0);
      check("t3_unlock", 32'(locked), 32'd0);
      check("t3_count", 32'(err_count), 32'd4);
      check("t3_sat_count", 32'(s_err_count), 32'd3);
      for (int i = 30; i < 34; i++) push_seq(i);
      check("t3_relock_pre", 32'(locked), 32'd0);
      push_seq(34);
      check("t3_relock", 32'(locked), 32'd1);
      check("t3_acq_uncounted", 32'(err_count), 32'd4);

      // Lockup word
      lockup_pulses = 0;
      push(1'b1, 4'hF, 1'b0);
      check("t4_lockup", 32'(lockup), 32'd1);
      push_seq(35);
      check("t4_lockup_end", 32'(lockup), 32'd0);
      push_seq(36);
      check("t4_lockup_pulses", 32'(lockup_pulses), 32'd1);
      check("t4_count", 32'(err_count), 32'd6);
      check("t4_sat_hold", 32'(s_err_count), 32'd3);
      check("t4_lock", 32'(locked), 32'd1);

      // Asynchronous reset while locked with DV high
      @(negedge clk);
      dv = 1'b1; data = seq[7];
      #2 rst = 1'b1;
      #1;
      check("t6_locked", 32'(locked), 32'd0);
      check("t6_count", 32'(err_count), 32'd0);
      check("t6_sat_count", 32'(s_err_count), 32'd0);
      check("t6_error", 32'(error), 32'd0);
      check("t6_lockup", 32'(lockup), 32'd0);
      check("t6_period", 32'(period), 32'd0);
      @(negedge clk);
      check("t6_hold", 32'(locked), 32'd0);
      rst = 1'b0; dv = 1'b0;
      for (int i = 0; i < 4; i++) push_seq(i);
      check("t6_relock_pre", 32'(locked), 32'd0);
      push_seq(4);
      check("t6_relock", 32'(locked), 32'd1);
      check("t6_relock_count", 32'(err_count), 32'd0);
      push(1'b0, 4'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
